// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_pkg
// Purpose  : Shared FIR definitions: state encoding, clog2, accumulator width.
// Revision : 1.0
// ============================================================================
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_t;

    localparam int c_shift_w    = 5;
    localparam int c_coef_idx_w = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Wide enough that TAPS full-scale products can never overflow the sum.
    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + clog2(taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_scale_sat.sv
`default_nettype none
// ============================================================================
// Module   : fir_scale_sat
// Purpose  : Combinational round-half-up, arithmetic shift and saturate/truncate.
// Revision : 1.0
// ============================================================================
module fir_scale_sat
    import fir_pkg::*;
#(
    parameter int ACC_W  = 19,
    parameter int DATA_W = 8
) (
    input  logic signed [ACC_W-1:0]     i_acc,
    input  logic        [c_shift_w-1:0] i_shift,
    input  logic                        i_sat_en,
    output logic signed [DATA_W-1:0]    o_result
);

    // Headroom for a rounding constant of up to 2^30 on top of the accumulator.
    localparam int c_ext_w = ((ACC_W > 31) ? ACC_W : 31) + 2;
    localparam logic signed [c_ext_w-1:0] c_max = {{(c_ext_w-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [c_ext_w-1:0] c_min = {{(c_ext_w-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [c_ext_w-1:0] w_ext;
    logic signed [c_ext_w-1:0] w_rnd;
    logic signed [c_ext_w-1:0] w_shifted;

    always_comb begin
        w_ext = c_ext_w'(i_acc);
        w_rnd = '0;
        if (i_shift != '0) w_rnd[i_shift - 5'd1] = 1'b1;
        w_shifted = (w_ext + w_rnd) >>> i_shift;
        o_result = w_shifted[DATA_W-1:0];
        if (i_sat_en) begin
            if (w_shifted > c_max)      o_result = c_max[DATA_W-1:0];
            else if (w_shifted < c_min) o_result = c_min[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : fir_pipe_param
// Purpose  : Memory-to-memory pipelined FIR filter, one sample per cycle.
// Revision : 1.0
// ============================================================================
module fir_pipe_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 5,
    parameter int ADDR_W = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic        [ADDR_W-1:0]       input_addr,
    input  logic        [ADDR_W-1:0]       output_addr,
    input  logic        [ADDR_W-1:0]       sample_count,
    input  logic        [c_shift_w-1:0]    shift,
    input  logic                           sat_en,
    input  logic                           coef_we,
    input  logic        [c_coef_idx_w-1:0] coef_idx,
    input  logic signed [COEF_W-1:0]       coef_data,
    output logic        [ADDR_W-1:0]       mem_addr_a,
    input  logic signed [DATA_W-1:0]       mem_data_out_a,
    output logic        [ADDR_W-1:0]       mem_addr_b,
    output logic signed [DATA_W-1:0]       mem_data_in_b,
    output logic                           mem_we_b,
    output logic                           busy,
    output logic                           done,
    output logic        [31:0]             cycle_count
);

    localparam int c_acc_w  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int c_prod_w = DATA_W + COEF_W;

    fir_state_t                  r_state;
    logic        [ADDR_W-1:0]    r_n;
    logic        [ADDR_W-1:0]    r_rd_cnt;
    logic        [ADDR_W-1:0]    r_mem_addr_a;
    logic        [ADDR_W-1:0]    r_mem_addr_b;
    logic        [ADDR_W-1:0]    r_wr_addr;
    logic        [c_shift_w-1:0] r_shift;
    logic                        r_sat_en;
    logic signed [COEF_W-1:0]    r_coef  [TAPS];
    logic signed [DATA_W-1:0]    r_dline [TAPS-1];
    logic signed [c_prod_w-1:0]  r_prod  [TAPS];
    logic signed [c_acc_w-1:0]   r_sum;
    logic signed [DATA_W-1:0]    r_wdata;
    logic                        r_v_cap;
    logic                        r_v_prod;
    logic                        r_v_sum;
    logic                        r_we;
    logic                        r_busy;
    logic                        r_done;
    logic        [31:0]          r_cycles;

    logic signed [DATA_W-1:0]    w_win [TAPS];
    logic signed [c_acc_w-1:0]   w_sum;
    logic signed [DATA_W-1:0]    w_scaled;

    // Tap 0 is the sample arriving from memory this cycle.
    assign w_win[0] = mem_data_out_a;
    for (genvar k = 1; k < TAPS; k++) begin : g_win
        assign w_win[k] = r_dline[k-1];
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_sum = w_sum + c_acc_w'(r_prod[k]);
        end
    end

    fir_scale_sat #(
        .ACC_W  (c_acc_w),
        .DATA_W (DATA_W)
    ) u_scale (
        .i_acc    (r_sum),
        .i_shift  (r_shift),
        .i_sat_en (r_sat_en),
        .o_result (w_scaled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_n          <= '0;
            r_rd_cnt     <= '0;
            r_mem_addr_a <= '0;
            r_mem_addr_b <= '0;
            r_wr_addr    <= '0;
            r_shift      <= '0;
            r_sat_en     <= 1'b0;
            r_sum        <= '0;
            r_wdata      <= '0;
            r_v_cap      <= 1'b0;
            r_v_prod     <= 1'b0;
            r_v_sum      <= 1'b0;
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cycles     <= '0;
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
                r_prod[k] <= '0;
            end
            for (int k = 0; k < TAPS-1; k++) r_dline[k] <= '0;
        end else begin
            r_done   <= 1'b0;
            r_v_cap  <= (r_state == ST_RUN);
            r_v_prod <= r_v_cap;
            r_v_sum  <= r_v_prod;
            r_we     <= r_v_sum;

            // A write coinciding with start is dropped so the run sees stable taps.
            if (r_state == ST_IDLE && coef_we && !start) begin
                for (int k = 0; k < TAPS; k++) begin
                    if (int'(coef_idx) == k) r_coef[k] <= coef_data;
                end
            end

            if (r_v_cap) begin
                r_dline[0] <= mem_data_out_a;
                for (int k = 1; k < TAPS-1; k++) r_dline[k] <= r_dline[k-1];
                for (int k = 0; k < TAPS; k++) begin
                    r_prod[k] <= c_prod_w'(w_win[k]) * c_prod_w'(r_coef[k]);
                end
            end
            if (r_v_prod) r_sum <= w_sum;
            if (r_v_sum) begin
                r_wdata      <= w_scaled;
                r_mem_addr_b <= r_wr_addr;
                r_wr_addr    <= r_wr_addr + ADDR_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shift      <= shift;
                        r_sat_en     <= sat_en;
                        r_n          <= sample_count;
                        r_rd_cnt     <= '0;
                        r_cycles     <= '0;
                        r_mem_addr_a <= input_addr;
                        r_wr_addr    <= output_addr;
                        r_busy       <= 1'b1;
                        for (int k = 0; k < TAPS-1; k++) r_dline[k] <= '0;
                        if (sample_count == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_cycles <= r_cycles + 32'd1;
                    if (r_rd_cnt == r_n - ADDR_W'(1)) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rd_cnt     <= r_rd_cnt + ADDR_W'(1);
                        r_mem_addr_a <= r_mem_addr_a + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_cycles <= r_cycles + 32'd1;
                    // Reads are contiguous, so a write with nothing behind it is the last.
                    if (r_we && !r_v_sum) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_cycles <= r_cycles + 32'd1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr_a    = r_mem_addr_a;
    assign mem_addr_b    = r_mem_addr_b;
    assign mem_data_in_b = r_wdata;
    assign mem_we_b      = r_we;
    assign busy          = r_busy;
    assign done          = r_done;
    assign cycle_count   = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_fir_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_pipe_param
// Purpose  : Vector-table and scoreboard bench for fir_pipe_param.
// Revision : 1.0
// ============================================================================
module tb_fir_pipe_param;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic        [9:0] input_addr;
    logic        [9:0] output_addr;
    logic        [9:0] sample_count;
    logic        [4:0] shift;
    logic              sat_en;
    logic              coef_we;
    logic        [3:0] coef_idx;
    logic signed [7:0] coef_data;
    logic        [9:0] mem_addr_a;
    logic signed [7:0] mem_data_out_a;
    logic        [9:0] mem_addr_b;
    logic signed [7:0] mem_data_in_b;
    logic              mem_we_b;
    logic              busy;
    logic              done;
    logic       [31:0] cycle_count;

    fir_pipe_param #(.DATA_W(8), .COEF_W(8), .TAPS(5), .ADDR_W(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .input_addr     (input_addr),
        .output_addr    (output_addr),
        .sample_count   (sample_count),
        .shift          (shift),
        .sat_en         (sat_en),
        .coef_we        (coef_we),
        .coef_idx       (coef_idx),
        .coef_data      (coef_data),
        .mem_addr_a     (mem_addr_a),
        .mem_data_out_a (mem_data_out_a),
        .mem_addr_b     (mem_addr_b),
        .mem_data_in_b  (mem_data_in_b),
        .mem_we_b       (mem_we_b),
        .busy           (busy),
        .done           (done),
        .cycle_count    (cycle_count)
    );

    always #5 clk = ~clk;

    logic signed [7:0] mem [1024];
    always @(posedge clk) mem_data_out_a <= mem[mem_addr_a];

    typedef struct {
        int coef[5];
        int shv;
        bit sat;
        int in_a;
        int out_a;
        int n;
        int x[8];
        int y[8];
    } vec_t;

    typedef struct {
        int addr;
        int data;
        int idx;
    } sb_t;

    vec_t tbl[8];
    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference filter: direct convolution, round half up, then clamp or wrap.
    function automatic int model_y(input int t, input int i);
        longint acc;
        logic signed [7:0] b;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (i - k >= 0) acc += longint'(tbl[t].coef[k]) * longint'(tbl[t].x[i-k]);
        end
        if (tbl[t].shv > 0) acc += longint'(1) << (tbl[t].shv - 1);
        acc = acc >>> tbl[t].shv;
        if (tbl[t].sat) begin
            if (acc > 127) acc = 127;
            else if (acc < -128) acc = -128;
            return int'(acc);
        end
        b = acc[7:0];
        return int'(b);
    endfunction

    task automatic check_write(input int c);
        sb_t e;
        if (sb.size() == 0) begin
            check("unexpected_write", 1, 0);
        end else begin
            e = sb.pop_front();
            check("wr_addr", mem_addr_b, e.addr);
            check("wr_data", mem_data_in_b, e.data);
            check("wr_cycle", c, e.idx + 4);
        end
    endtask

    task automatic write_coef(input int idx, input int val);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_idx  = 4'(idx);
        coef_data = 8'(val);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic run(input int in_a, input int out_a, input int n, input int shv,
                       input bit sat, input bit disturb);
        int  c;
        bit  got_done;
        @(negedge clk);
        input_addr   = 10'(in_a);
        output_addr  = 10'(out_a);
        sample_count = 10'(n);
        shift        = 5'(shv);
        sat_en       = sat;
        start        = 1'b1;
        if (disturb) begin
            coef_we = 1'b1; coef_idx = 4'd0; coef_data = 8'sd100;
        end
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            coef_idx = 4'd1; coef_data = 8'sd50;
        end
        c = 0;
        got_done = 1'b0;
        while (!got_done && c < n + 30) begin
            if (c == 1) coef_we = 1'b0;
            if (c < n) check("rd_addr", mem_addr_a, (in_a + c) % 1024);
            if (mem_we_b) check_write(c);
            check("busy_run", busy, 1);
            if (done) begin
                got_done = 1'b1;
                check("done_cycle", c, (n == 0) ? 0 : n + 4);
            end
            @(negedge clk);
            c++;
        end
        coef_we = 1'b0;
        check("done_seen", got_done, 1);
        check("sb_empty", sb.size(), 0);
        check("cycle_count", cycle_count, (n == 0) ? 1 : n + 5);
        check("busy_after", busy, 0);
    endtask

    task automatic apply_case(input int t);
        for (int k = 0; k < 5; k++) write_coef(k, tbl[t].coef[k]);
        for (int i = 0; i < tbl[t].n; i++) begin
            mem[(tbl[t].in_a + i) % 1024] = 8'(tbl[t].x[i]);
            sb.push_back('{addr: (tbl[t].out_a + i) % 1024, data: tbl[t].y[i], idx: i});
        end
        run(tbl[t].in_a, tbl[t].out_a, tbl[t].n, tbl[t].shv, tbl[t].sat, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst = 1'b1; start = 1'b0; input_addr = '0; output_addr = '0; sample_count = '0;
        shift = '0; sat_en = 1'b0; coef_we = 1'b0; coef_idx = '0; coef_data = '0;

        tbl[0] = '{coef: '{1,2,3,4,5}, shv: 0, sat: 1, in_a: 0, out_a: 100, n: 8,
                   x: '{1,0,0,0,0,0,0,0}, y: '{1,2,3,4,5,0,0,0}};
        tbl[1] = '{coef: '{127,127,127,127,127}, shv: 0, sat: 1, in_a: 20, out_a: 120, n: 6,
                   x: '{127,127,127,127,127,127,0,0}, y: '{127,127,127,127,127,127,0,0}};
        tbl[2] = '{coef: '{127,127,127,127,127}, shv: 0, sat: 0, in_a: 20, out_a: 140, n: 6,
                   x: '{127,127,127,127,127,127,0,0}, y: '{1,2,3,4,5,5,0,0}};
        tbl[3] = '{coef: '{127,127,127,127,127}, shv: 0, sat: 1, in_a: 40, out_a: 160, n: 3,
                   x: '{-128,-128,-128,0,0,0,0,0}, y: '{-128,-128,-128,0,0,0,0,0}};
        tbl[4] = '{coef: '{64,0,0,0,0}, shv: 7, sat: 1, in_a: 50, out_a: 180, n: 2,
                   x: '{3,-3,0,0,0,0,0,0}, y: '{2,-1,0,0,0,0,0,0}};
        tbl[5] = '{coef: '{1,0,0,0,0}, shv: 0, sat: 1, in_a: 1020, out_a: 1022, n: 8,
                   x: '{11,12,13,14,15,16,17,18}, y: '{11,12,13,14,15,16,17,18}};
        tbl[6] = '{coef: '{3,-2,5,-7,1}, shv: 2, sat: 1, in_a: 60, out_a: 200, n: 8,
                   x: '{10,-20,30,-40,50,-60,70,-80}, y: '{0,0,0,0,0,0,0,0}};
        for (int i = 0; i < 8; i++) tbl[6].y[i] = model_y(6, i);
        tbl[7] = '{coef: '{1,2,3,4,5}, shv: 0, sat: 1, in_a: 0, out_a: 0, n: 0,
                   x: '{0,0,0,0,0,0,0,0}, y: '{0,0,0,0,0,0,0,0}};

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mem_we_b, 0);
        check("rst_addr_a", mem_addr_a, 0);
        check("rst_addr_b", mem_addr_b, 0);
        check("rst_wdata", mem_data_in_b, 0);
        check("rst_count", cycle_count, 0);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) apply_case(t);

        // Coefficients must survive a same-cycle start write, a busy write and an out-of-range index.
        for (int k = 0; k < 5; k++) write_coef(k, k + 1);
        write_coef(9, 77);
        for (int i = 0; i < 8; i++) mem[i] = (i == 0) ? 8'sd1 : 8'sd0;
        for (int i = 0; i < 8; i++) sb.push_back('{addr: 100 + i, data: tbl[0].y[i], idx: i});
        run(0, 100, 8, 0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) sb.push_back('{addr: 100 + i, data: tbl[0].y[i], idx: i});
        run(0, 100, 8, 0, 1'b1, 1'b0);

        // Reset during an N=20 run: three writes land, then everything stops.
        for (int i = 0; i < 20; i++) mem[200 + i] = 8'(i + 1);
        sb.push_back('{addr: 300, data: 1,  idx: 0});
        sb.push_back('{addr: 301, data: 4,  idx: 1});
        sb.push_back('{addr: 302, data: 10, idx: 2});
        @(negedge clk);
        input_addr = 10'd200; output_addr = 10'd300; sample_count = 10'd20;
        shift = 5'd0; sat_en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            if (mem_we_b) check_write(c);
            check("busy_pre_rst", busy, 1);
            if (c == 6) begin
                rst = 1'b1;
                start = 1'b1;
            end
            @(negedge clk);
        end
        check("sb_rst_empty", sb.size(), 0);
        for (int c = 0; c < 3; c++) begin
            check("rst_hold_busy", busy, 0);
            check("rst_hold_we", mem_we_b, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 25; c++) begin
            check("post_rst_we", mem_we_b, 0);
            check("post_rst_done", done, 0);
            @(negedge clk);
        end
        check("post_rst_count", cycle_count, 0);
        check("post_rst_addr_a", mem_addr_a, 0);
        check("post_rst_addr_b", mem_addr_b, 0);
        check("post_rst_wdata", mem_data_in_b, 0);

        for (int i = 0; i < 4; i++) sb.push_back('{addr: 400 + i, data: 0, idx: i});
        run(200, 400, 4, 0, 1'b1, 1'b0);
        apply_case(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_pipe_param.md
FIR_PIPE_PARAM -- requirements
Module: fir_pipe_param

Interface
REQ-001 Parameter DATA_W, default 8, signed sample width (input and output).
REQ-002 Parameter COEF_W, default 8, signed coefficient width.
REQ-003 Parameter TAPS, default 5, tap count, legal range 2..16.
REQ-004 Parameter ADDR_W, default 10, sample memory address width.
REQ-005 Port clk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port start  in  1  run request; sampled only in IDLE.
REQ-008 Port input_addr, output_addr  in  ADDR_W  base addresses of input and output buffers.
REQ-009 Port sample_count  in  ADDR_W  number of samples N to filter.
REQ-010 Port shift  in  5  arithmetic right shift applied to the accumulator; sat_en  in  1  1=saturate, 0=truncate.
REQ-011 Port coef_we  in  1; coef_idx  in  4; coef_data  in  COEF_W  coefficient write port.
REQ-012 Port mem_addr_a  out  ADDR_W; mem_data_out_a  in  DATA_W  read port, 1-cycle read latency.
REQ-013 Port mem_addr_b  out  ADDR_W; mem_data_in_b  out  DATA_W; mem_we_b  out  1  write port.
REQ-014 Port busy  out  1; done  out  1  one-cycle pulse; cycle_count  out  32.

Function
REQ-015 y[n] = scale(sum over k=0..TAPS-1 of coef[k]*x[n-k]), with x[m]=0 for m<0 (history zeroed at every run start).
REQ-016 Accumulator width ACC_W = DATA_W+COEF_W+clog2(TAPS); no internal overflow permitted.
REQ-017 scale: add rounding constant 2^(shift-1) when shift>0, then arithmetic shift right by shift; then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when sat_en=1, else keep the low DATA_W bits.
REQ-018 shift and sat_en are latched at start acceptance and held for the run.
REQ-019 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start=1 with N>0; IDLE->DONE on start=1 with N=0; RUN->DRAIN after the N-th read issues; DRAIN->DONE after the last write; DONE->IDLE unconditionally after one cycle.
REQ-020 In RUN, read address input_addr+i is driven in the i-th cycle after acceptance (i=0..N-1), one sample per cycle.
REQ-021 Pipeline: read, capture into delay line, registered products, registered adder sum, registered scaled result; mem_we_b for sample i asserts exactly 4 cycles after its read address, with mem_addr_b = output_addr+i.
REQ-022 All address arithmetic wraps modulo 2^ADDR_W.
REQ-023 done pulses in DONE; for N>=1 it occurs N+5 cycles after acceptance, for N=0 one cycle after acceptance, with no writes.
REQ-024 busy=1 in RUN, DRAIN, DONE; start while busy is ignored.
REQ-025 cycle_count clears at acceptance, increments each busy cycle, freezes at done (N+5 for N>=1, 1 for N=0) and holds until the next acceptance.
REQ-026 Coefficient writes take effect only in IDLE; coef_we while busy is ignored; coef_idx>=TAPS is ignored.
REQ-027 Same-cycle start and coef_we in IDLE: the write is discarded, the run uses the prior coefficients.

Reset
REQ-028 rst forces IDLE; busy, done, mem_we_b=0; mem_addr_a, mem_addr_b, mem_data_in_b, cycle_count=0; all coefficients, delay line and pipeline registers=0.
REQ-029 rst mid-run aborts immediately: no further mem_we_b assertions, no done pulse; rst overrides start.

Structure
REQ-030 Package fir_pkg holds the state encoding, the clog2 function and ACC_W derivation, shared with the existing FIR filters.
REQ-031 One sub-module fir_scale_sat (combinational round/shift/saturate) instantiated at the final pipeline stage.

Verification
REQ-032 Impulse: coef={1,2,3,4,5}, shift=0, sat_en=1, x=[1,0,0,0,0,0,0,0], N=8 -> outputs 1,2,3,4,5,0,0,0; cycle_count=13.
REQ-033 Saturation: coef all 127, x all 127, N=6, shift=0 -> sat_en=1 gives 127 every sample; sat_en=0 gives low 8 bits of the exact sum (x[0]: 0x01).
REQ-034 Rounding: coef={64,0,0,0,0}, x=[3,-3], shift=7 -> outputs 2,-1.
REQ-035 Wrap: input_addr=1020, output_addr=1022, N=8 -> reads at 1020..1023,0..3 and writes at 1022,1023,0..5, in order.
REQ-036 N=0 -> done one cycle after acceptance, cycle_count=1, mem_we_b never asserts.
REQ-037 rst asserted in cycle 6 of an N=20 run -> mem_we_b low from the next edge, no done pulse; a following run produces correct outputs from zeroed history with all coefficients 0 until reloaded.
